// File: rtl/exec_ctrl.sv
// Run/load sequencer: shares instruction memory between host loader and CPU fetch, gates CPU via cpu_en.
// Latency: all outputs combinational from registered state; one-cycle state transitions.
// Backpressure: load_ready high only in LOAD; host holds load_valid/addr/data until accepted.
//
// Ports:
//   clk, rst_n                       clock and async active-low reset
//   load_valid/ready/addr/data/done  host program-load handshake
//   run, step, halt                  execution command pulses
//   bp_en, bp_addr, pc               breakpoint control and current PC
//   cpu_en, pc_clr                   CPU execution enable and PC clear
//   mem_we/addr/wdata/rdata          shared instruction memory port
//   inst                             instruction to control unit
//   state, cycle_cnt                 status: FSM state and executed-cycle count
module exec_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [15:0]      load_addr,
  input  logic [15:0]      load_data,
  input  logic             load_done,
  input  logic             run,
  input  logic             step,
  input  logic             halt,
  input  logic             bp_en,
  input  logic [15:0]      bp_addr,
  input  logic [15:0]      pc,
  output logic             cpu_en,
  output logic             pc_clr,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  output logic [15:0]      inst,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  localparam bit             WD_EN    = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             bp_skip_q, bp_skip_d;
  logic             in_load, bp_hit, wd_trip;

  assign in_load = (state_q == S_LOAD);

  // The breakpoint blocks execution in the very cycle the PC reaches it, so the
  // instruction at bp_addr is not executed until the run is resumed.
  assign bp_hit = (state_q == S_RUN) && bp_en && (pc == bp_addr) && !bp_skip_q;

  assign cpu_en     = ((state_q == S_RUN) && !bp_hit) || (state_q == S_STEP);
  assign load_ready = in_load;
  assign mem_we     = in_load && load_valid;
  assign pc_clr     = in_load && load_done;
  assign state      = state_q;
  assign cycle_cnt  = cnt_q;

  always_comb begin
    mem_addr  = pc;
    mem_wdata = '0;
    inst      = mem_rdata;
    if (in_load) begin
      mem_addr  = load_addr;
      mem_wdata = load_data;
      inst      = '0;
    end
  end

  // Saturating count of executed cycles; the watchdog looks at the value after
  // this cycle so the cycle reaching the limit is the last one executed.
  assign cnt_inc = (cpu_en && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign wd_trip = WD_EN && (cnt_inc >= WD_LIMIT);

  always_comb begin
    state_d   = state_q;
    bp_skip_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_valid)  state_d = S_LOAD;
        else if (halt)   state_d = S_IDLE;
        else if (step)   state_d = S_STEP;
        else if (run)    state_d = S_RUN;
      end
      S_LOAD: begin
        if (load_done)   state_d = S_IDLE;
      end
      S_RUN: begin
        if (bp_hit || halt || wd_trip) state_d = S_HALTED;
      end
      S_STEP: begin
        state_d = S_HALTED;
      end
      S_HALTED: begin
        if (load_valid)  state_d = S_LOAD;
        else if (halt)   state_d = S_HALTED;
        else if (step)   state_d = S_STEP;
        else if (run) begin
          // Resuming must get past the breakpoint we may be parked on.
          state_d   = S_RUN;
          bp_skip_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = ((state_d == S_LOAD) && !in_load) ? '0 : cnt_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bp_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bp_skip_q <= bp_skip_d;
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rst_w_n;
  logic        load_valid, load_done, run, step, halt, bp_en;
  logic [15:0] load_addr, load_data, bp_addr;
  logic        load_ready, cpu_en, pc_clr, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, inst;
  logic [2:0]  st;
  logic [31:0] cycle_cnt;
  logic [15:0] pc, pc_w;

  logic        run_w, halt_w;
  logic        load_ready_w, cpu_en_w, pc_clr_w, mem_we_w;
  logic [15:0] mem_addr_w, mem_wdata_w, mem_rdata_w, inst_w;
  logic [2:0]  st_w;
  logic [31:0] cycle_cnt_w;

  logic [15:0] mem [0:255];
  logic [15:0] words [0:3];
  logic [15:0] wlog_a[$], wlog_d[$], exp_a[$], exp_d[$];
  int tests = 0, fails = 0;
  int en_cnt = 0, en_w_cnt = 0;
  int exp_pc, exp_cnt;

  always #5 clk = ~clk;

  exec_ctrl #(.CNT_W(32), .MAX_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .run(run), .step(step), .halt(halt), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .cpu_en(cpu_en), .pc_clr(pc_clr), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .inst(inst), .state(st), .cycle_cnt(cycle_cnt)
  );

  exec_ctrl #(.CNT_W(32), .MAX_CYCLES(5)) dut_wd (
    .clk(clk), .rst_n(rst_w_n), .load_valid(1'b0), .load_ready(load_ready_w),
    .load_addr(16'h0), .load_data(16'h0), .load_done(1'b0),
    .run(run_w), .step(1'b0), .halt(halt_w), .bp_en(1'b0), .bp_addr(16'h0),
    .pc(pc_w), .cpu_en(cpu_en_w), .pc_clr(pc_clr_w), .mem_we(mem_we_w),
    .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .mem_rdata(mem_rdata_w),
    .inst(inst_w), .state(st_w), .cycle_cnt(cycle_cnt_w)
  );

  // Environment: combinational-read memory and a PC counter for a 4-word looping program.
  assign mem_rdata   = mem[mem_addr[7:0]];
  assign mem_rdata_w = mem[mem_addr_w[7:0]];

  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (pc_clr) pc <= '0;
    else if (cpu_en) pc <= (pc == 16'd3) ? 16'd0 : pc + 16'd1;

  always @(posedge clk or negedge rst_w_n)
    if (!rst_w_n) pc_w <= '0;
    else if (cpu_en_w) pc_w <= (pc_w == 16'd3) ? 16'd0 : pc_w + 16'd1;

  always @(negedge clk) begin
    if (cpu_en) en_cnt++;
    if (cpu_en_w) en_w_cnt++;
    if (mem_we) begin
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    load_valid = 1'b1; load_addr = a; load_data = d;
    exp_a.push_back(a); exp_d.push_back(d);
    for (int i = 0; i < 5 && !ok; i++) begin
      #1;
      ok = load_ready;
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    if (!ok) check("load_accept_timeout", 0, 1);
  endtask

  // Issues run from HALTED/IDLE and waits (bounded) for HALTED; returns cycles executed.
  task automatic run_until_halt(input string tag, output int executed);
    int e0;
    bit done;
    e0 = en_cnt;
    done = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (st == 3'd4) done = 1'b1;
      else tick();
    end
    if (!done) check({tag, "_halt_timeout"}, 0, 1);
    executed = en_cnt - e0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int e0, ex, r, b, op, gaps;
    logic [15:0] jd, ja;
    words[0] = 16'd36816; words[1] = 16'd34768; words[2] = 16'd1; words[3] = 16'd32775;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    rst_n = 1'b0; rst_w_n = 1'b0;
    load_valid = 0; load_done = 0; run = 0; step = 0; halt = 0; bp_en = 0;
    load_addr = 0; load_data = 0; bp_addr = 0; run_w = 0; halt_w = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", st, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_pc_clr", pc_clr, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    rst_n = 1'b1;
    tick();

    // ---- program load with random junk word and random idle gaps ----
    ja = 16'($urandom_range(16, 31)); jd = 16'($urandom);
    load_word(ja, jd);
    check("load_state", st, 1);
    for (int k = 0; k < 3; k++) begin
      load_word(16'(k), words[k]);
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        run = 1'b1; step = 1'b1;
        #1;
        check("gap_mem_we", mem_we, 0);
        check("gap_load_ready", load_ready, 1);
        tick();
        run = 1'b0; step = 1'b0;
        check("gap_cmd_ignored", st, 1);
      end
    end
    load_valid = 1'b1; load_addr = 16'd3; load_data = words[3]; load_done = 1'b1;
    exp_a.push_back(16'd3); exp_d.push_back(words[3]);
    #1;
    check("done_pc_clr", pc_clr, 1);
    check("done_mem_we", mem_we, 1);
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    check("done_state_idle", st, 0);
    check("done_pc_zero", pc, 0);
    check("done_pc_clr_pulse", pc_clr, 0);
    check("wlog_count", wlog_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wlog_a.size(); i++) begin
      check($sformatf("wlog_addr%0d", i), wlog_a[i], exp_a[i]);
      check($sformatf("wlog_data%0d", i), wlog_d[i], exp_d[i]);
    end

    // ---- run for 10 cycles then halt ----
    e0 = en_cnt;
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("run_inst%0d", i), inst, words[pc[1:0]]);
      tick();
    end
    halt = 1'b1; tick(); halt = 1'b0;
    check("run_en_cycles", en_cnt - e0, 11);
    check("run_cycle_cnt", cycle_cnt, 11);
    check("run_state_halted", st, 4);
    check("run_pc", pc, 3);
    exp_pc = 3; exp_cnt = 11;

    // ---- three single steps, first one sitting on the breakpoint ----
    bp_en = 1'b1; bp_addr = 16'd3;
    for (int i = 0; i < 3; i++) begin
      e0 = en_cnt;
      step = 1'b1; tick(); step = 1'b0;
      check($sformatf("step%0d_state", i), st, 3);
      check($sformatf("step%0d_cpu_en", i), cpu_en, 1);
      tick();
      check($sformatf("step%0d_halted", i), st, 4);
      check($sformatf("step%0d_en", i), en_cnt - e0, 1);
    end
    exp_pc = 2; exp_cnt = 14;
    check("step_cycle_cnt", cycle_cnt, exp_cnt);

    // ---- breakpoint at 3: run from pc 2 ----
    run = 1'b1; tick(); run = 1'b0;
    check("bp_first_cpu_en", cpu_en, 1);
    tick();
    check("bp_hit_pc", pc, 3);
    check("bp_hit_cpu_en", cpu_en, 0);
    tick();
    check("bp_hit_halted", st, 4);
    check("bp_cnt1", cycle_cnt, 15);
    // resume from the breakpoint: executes 3,0,1,2 then hits again
    run_until_halt("bp_resume", ex);
    check("bp_resume_exec", ex, 4);
    check("bp_resume_pc", pc, 3);
    exp_pc = 3; exp_cnt = 19;
    check("bp_resume_cnt", cycle_cnt, exp_cnt);

    // ---- randomized command sequence against arithmetic model ----
    for (int k = 0; k < 8; k++) begin
      op = $urandom_range(0, 2);
      e0 = en_cnt;
      if (op == 0) begin
        bp_en = 1'($urandom_range(0, 1)); bp_addr = 16'(exp_pc);
        step = 1'b1; tick(); step = 1'b0;
        tick();
        ex = 1;
      end else if (op == 1) begin
        bp_en = 1'b0;
        r = $urandom_range(0, 6);
        run = 1'b1; tick(); run = 1'b0;
        repeat (r) tick();
        halt = 1'b1; tick(); halt = 1'b0;
        ex = r + 1;
      end else begin
        b = $urandom_range(0, 3);
        bp_en = 1'b1; bp_addr = 16'(b);
        run_until_halt($sformatf("rnd%0d", k), r);
        ex = ((b - exp_pc + 7) % 4) + 1;
      end
      exp_pc = (exp_pc + ex) % 4;
      exp_cnt = exp_cnt + ex;
      check($sformatf("rnd%0d_op%0d_en", k, op), en_cnt - e0, ex);
      check($sformatf("rnd%0d_cnt", k), cycle_cnt, exp_cnt);
      check($sformatf("rnd%0d_pc", k), pc, exp_pc);
      check($sformatf("rnd%0d_state", k), st, 4);
    end
    bp_en = 1'b0;

    // ---- reload from HALTED clears the counter ----
    load_word(16'd0, words[0]);
    check("reload_state", st, 1);
    check("reload_cnt_clr", cycle_cnt, 0);
    load_done = 1'b1;
    #1;
    check("reload_pc_clr", pc_clr, 1);
    tick();
    load_done = 1'b0;
    check("reload_idle", st, 0);

    // ---- asynchronous reset mid-RUN ----
    run = 1'b1; tick(); run = 1'b0;
    repeat (3) tick();
    check("prerst_run", st, 2);
    rst_n = 1'b0;
    #1;
    check("rstrun_state", st, 0);
    check("rstrun_cpu_en", cpu_en, 0);
    check("rstrun_cnt", cycle_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- asynchronous reset mid-LOAD with a write in flight ----
    load_valid = 1'b1; load_addr = 16'd5; load_data = 16'($urandom);
    tick();
    check("prerst_load_we", mem_we, 1);
    r = wlog_a.size();
    rst_n = 1'b0;
    #1;
    check("rstload_state", st, 0);
    check("rstload_mem_we", mem_we, 0);
    check("rstload_cnt", cycle_cnt, 0);
    tick();
    load_valid = 1'b0;
    check("rstload_no_write", wlog_a.size(), r);
    rst_n = 1'b1;
    tick();

    // ---- watchdog instance, limit 5 ----
    rst_w_n = 1'b1;
    tick();
    e0 = en_w_cnt;
    run_w = 1'b1; tick(); run_w = 1'b0;
    r = 0;
    for (int i = 0; i < 20 && st_w != 3'd4; i++) begin
      tick();
      r++;
    end
    check("wd_halted", st_w, 4);
    check("wd_exec", en_w_cnt - e0, 5);
    check("wd_cnt", cycle_cnt_w, 5);
    check("wd_load_ready", load_ready_w, 0);
    halt_w = 1'b1; run_w = 1'b1; tick(); halt_w = 1'b0; run_w = 1'b0;
    check("wd_haltrun_state", st_w, 4);
    check("wd_haltrun_cpu_en", cpu_en_w, 0);
    tick();
    check("wd_haltrun_cnt", cycle_cnt_w, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
